// File: rtl/edge_rate_meter.sv
// edge_rate_meter
//   Counts rising edges on CHANNELS asynchronous inputs over a fixed gate
//   window of GATE_CYCLES clk cycles. At the end of every window it latches
//   each channel's count together with a liveness flag and an overflow flag.
//   Each channel also drives a blink LED taken from a free-running divider
//   of its own edge stream.
//
// Ports
//   clk          system clock (only clock)
//   rst          synchronous, active-high reset
//   sig_in       asynchronous inputs, one per channel
//   count_out    latched per-channel counts, channel i at [i*CNT_W +: CNT_W]
//   count_valid  one-cycle pulse when count_out/alive/overflow update
//   alive        latched count >= MIN_COUNT
//   overflow     channel saturated during the last window
//   led          per-channel blink output, dark while the channel is not alive
module edge_rate_meter #(
  parameter int CHANNELS    = 2,
  parameter int GATE_CYCLES = 48000000,
  parameter int CNT_W       = 26,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_COUNT   = 1,
  parameter int LED_BIT     = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       sig_in,
  output logic [CHANNELS*CNT_W-1:0] count_out,
  output logic                      count_valid,
  output logic [CHANNELS-1:0]       alive,
  output logic [CHANNELS-1:0]       overflow,
  output logic [CHANNELS-1:0]       led
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(MIN_COUNT);

  // Gate counter shared by all channels
  logic [GW-1:0] gate;
  logic          term;

  assign term = (gate == GATE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      gate        <= '0;
      count_valid <= 1'b0;
    end else begin
      gate        <= term ? '0 : gate + GW'(1);
      count_valid <= term;
    end
  end

  logic [CHANNELS-1:0][CNT_W-1:0] cnt;
  assign count_out = cnt;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] vld_pipe;
    logic                   s, prev, primed, edg, acc_full;
    logic [CNT_W-1:0]       acc, acc_nxt, cnt_q;
    logic                   ovf_acc, ovf_q, alive_q;
    logic [LED_BIT:0]       div;

    assign s        = sync_q[SYNC_STAGES-1];
    assign edg      = s & ~prev & primed;
    assign acc_full = (acc == CNT_MAX);
    // Saturating next value; includes an edge landing on the terminal cycle
    assign acc_nxt  = (edg & ~acc_full) ? acc + CNT_W'(1) : acc;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q   <= '0;
        vld_pipe <= '0;
        prev     <= 1'b0;
        primed   <= 1'b0;
        acc      <= '0;
        ovf_acc  <= 1'b0;
        div      <= '0;
        cnt_q    <= '0;
        ovf_q    <= 1'b0;
        alive_q  <= 1'b0;
      end else begin
        sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in[i]};
        // vld_pipe tracks which sync stages hold real samples since reset;
        // the zeros loaded by reset must not prime the channel, otherwise
        // an input held high through reset would count as a fresh edge.
        vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
        prev     <= s;
        if (vld_pipe[SYNC_STAGES-1] && !s) primed <= 1'b1;
        if (edg) div <= div + (LED_BIT+1)'(1);
        if (term) begin
          cnt_q   <= acc_nxt;
          ovf_q   <= ovf_acc | (edg & acc_full);
          alive_q <= (acc_nxt >= MIN_CNT);
          acc     <= '0;
          ovf_acc <= 1'b0;
        end else begin
          acc <= acc_nxt;
          if (edg && acc_full) ovf_acc <= 1'b1;
        end
      end
    end

    assign cnt[i]      = cnt_q;
    assign alive[i]    = alive_q;
    assign overflow[i] = ovf_q;
    assign led[i]      = div[LED_BIT] & alive_q;
  end

endmodule

// File: tb/tb_edge_rate_meter.sv
module tb_edge_rate_meter;
  localparam int G  = 100;
  localparam int S  = 2;
  localparam int LB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sig_in = 2'b00;

  always #5 clk = ~clk;

  // Two instances share stimulus: 8-bit counters and 5-bit saturating counters
  logic [15:0] cnt_a;
  logic [9:0]  cnt_b;
  logic        cv_a, cv_b;
  logic [1:0]  alive_a, alive_b, ovf_a, ovf_b, led_a, led_b;

  edge_rate_meter #(.CHANNELS(2), .GATE_CYCLES(G), .CNT_W(8), .SYNC_STAGES(S),
                    .MIN_COUNT(1), .LED_BIT(LB)) dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_in), .count_out(cnt_a),
    .count_valid(cv_a), .alive(alive_a), .overflow(ovf_a), .led(led_a));

  edge_rate_meter #(.CHANNELS(2), .GATE_CYCLES(G), .CNT_W(5), .SYNC_STAGES(S),
                    .MIN_COUNT(1), .LED_BIT(LB)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_in), .count_out(cnt_b),
    .count_valid(cv_b), .alive(alive_b), .overflow(ovf_b), .led(led_b));

  logic [39:0] obs_all;
  assign obs_all = {cv_a, cnt_a, alive_a, ovf_a, led_a, cv_b, cnt_b, alive_b, ovf_b, led_b};

  int total = 0;
  int bad   = 0;

  // Reference model: input history per cycle since release, edges counted
  // per window with plain integer arithmetic, clipped at the end.
  int          t;
  bit          in_rst;
  logic [1:0]  hist [0:4095];
  int          win_n [2];
  int          tot [2];
  logic        exp_cv;
  logic [7:0]  ea [2];
  logic [4:0]  eb [2];
  logic [1:0]  eal_a, eal_b, eov_a, eov_b, eled_a, eled_b;
  logic [39:0] exp_all;

  function automatic logic [39:0] pack_exp();
    return {exp_cv, ea[1], ea[0], eal_a, eov_a, eled_a,
            exp_cv, eb[1], eb[0], eal_b, eov_b, eled_b};
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      win_n[c] = 0; tot[c] = 0; ea[c] = '0; eb[c] = '0;
    end
    exp_cv = 1'b0;
    eal_a = '0; eal_b = '0; eov_a = '0; eov_b = '0; eled_a = '0; eled_b = '0;
    exp_all = pack_exp();
  endtask

  // Apply everything that happens during cycle tc; leaves expectations for tc+1
  task automatic model_advance(input int tc);
    int j;
    j = tc - S;
    for (int c = 0; c < 2; c++) begin
      // a low->high change seen in two consecutive post-reset samples is an edge
      if (j >= 1 && hist[j][c] && !hist[j-1][c]) begin
        win_n[c]++; tot[c]++;
      end
    end
    exp_cv = ((tc % G) == G - 1);
    if (exp_cv) begin
      for (int c = 0; c < 2; c++) begin
        ea[c]    = (win_n[c] > 255) ? 8'd255 : 8'(win_n[c]);
        eb[c]    = (win_n[c] > 31)  ? 5'd31  : 5'(win_n[c]);
        eov_a[c] = (win_n[c] > 255);
        eov_b[c] = (win_n[c] > 31);
        eal_a[c] = (ea[c] >= 1);
        eal_b[c] = (eb[c] >= 1);
        win_n[c] = 0;
      end
    end
    for (int c = 0; c < 2; c++) begin
      eled_a[c] = (((tot[c] >> LB) & 1) != 0) && eal_a[c];
      eled_b[c] = (((tot[c] >> LB) & 1) != 0) && eal_b[c];
    end
    exp_all = pack_exp();
  endtask

  // One clk cycle with rst low; ends at the negedge with exp_all valid for t
  task automatic step(input logic [1:0] s);
    @(posedge clk); #1;
    if (in_rst) begin
      in_rst = 1'b0; t = 0; model_clear();
    end else begin
      model_advance(t); t++;
    end
    rst = 1'b0;
    sig_in = s;
    hist[t] = s;
    @(negedge clk);
  endtask

  task automatic reset_cycles(input int n, input logic [1:0] s);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      rst = 1'b1; sig_in = s; in_rst = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      rst = 1'b1; sig_in = 2'b00; in_rst = 1'b1;
      @(negedge clk);
      if (k > 0) begin
        total++;
        if (obs_all !== 40'h0) begin
          bad++; $display("FAIL reset k=%0d got=%h exp=0", k, obs_all);
        end
      end
    end
    for (int k = 0; k < 205; k++) begin
      step(2'b00);
      total++;
      if (obs_all !== exp_all) begin
        bad++; $display("FAIL idle t=%0d got=%h exp=%h", t, obs_all, exp_all);
      end
      if (t == 100 || t == 200) begin
        total++;
        if (cv_a !== 1'b1 || cnt_a !== 16'h0 || alive_a !== 2'b00 || led_a !== 2'b00) begin
          bad++; $display("FAIL idle_pulse t=%0d cv=%b cnt=%h alive=%b", t, cv_a, cnt_a, alive_a);
        end
      end
    end
  endtask

  task automatic test_steady();
    int ph, nv;
    ph = $urandom_range(0, 9); nv = 0;
    for (int k = 0; k < 300; k++) begin
      step(((k + ph) % 10) >= 5 ? 2'b01 : 2'b00);
      total++;
      if (obs_all !== exp_all) begin
        bad++; $display("FAIL steady t=%0d got=%h exp=%h", t, obs_all, exp_all);
      end
      if (t % G == 0) begin
        nv++;
        if (nv >= 2) begin
          total++;
          if (cnt_a !== 16'h000A || alive_a !== 2'b01 || ovf_a !== 2'b00) begin
            bad++; $display("FAIL steady_rate t=%0d cnt=%h alive=%b exp cnt=000a alive=01", t, cnt_a, alive_a);
          end
        end
      end
    end
  endtask

  task automatic test_saturation();
    int nv;
    nv = 0;
    for (int k = 0; k < 300; k++) begin
      step((k % 2) != 0 ? 2'b10 : 2'b00);
      total++;
      if (obs_all !== exp_all) begin
        bad++; $display("FAIL sat t=%0d got=%h exp=%h", t, obs_all, exp_all);
      end
      if (t % G == 0) begin
        nv++;
        if (nv >= 2) begin
          total++;
          if (cnt_b[9:5] !== 5'd31 || ovf_b[1] !== 1'b1 || cnt_a[15:8] !== 8'd50 || ovf_a[1] !== 1'b0) begin
            bad++; $display("FAIL sat_clip t=%0d b=%0d ovf_b=%b a=%0d exp b=31 ovf=1 a=50", t, cnt_b[9:5], ovf_b[1], cnt_a[15:8]);
          end
        end
      end
    end
    nv = 0;
    for (int k = 0; k < 250; k++) begin
      step(2'b00);
      total++;
      if (obs_all !== exp_all) begin
        bad++; $display("FAIL sat_stop t=%0d got=%h exp=%h", t, obs_all, exp_all);
      end
      if (t % G == 0) begin
        nv++;
        if (nv == 2) begin
          total++;
          if (cnt_b[9:5] !== 5'd0 || ovf_b[1] !== 1'b0) begin
            bad++; $display("FAIL sat_clear t=%0d b=%0d ovf_b=%b exp 0/0", t, cnt_b[9:5], ovf_b[1]);
          end
        end
      end
    end
  endtask

  task automatic test_boundary();
    reset_cycles(2, 2'b00);
    for (int k = 0; k < 250; k++) begin
      step(k == 97 ? 2'b01 : 2'b00);
      total++;
      if (obs_all !== exp_all) begin
        bad++; $display("FAIL boundary t=%0d got=%h exp=%h", t, obs_all, exp_all);
      end
      if (t == 100 || t == 200) begin
        total++;
        if (cv_a !== 1'b1 || cnt_a[7:0] !== ((t == 100) ? 8'd1 : 8'd0)) begin
          bad++; $display("FAIL boundary_win t=%0d cv=%b cnt=%0d", t, cv_a, cnt_a[7:0]);
        end
      end
    end
  endtask

  task automatic test_high_reset();
    reset_cycles(5, 2'b01);
    for (int k = 0; k < 410; k++) begin
      step((k >= 300 && k < 305) ? 2'b00 : 2'b01);
      total++;
      if (obs_all !== exp_all) begin
        bad++; $display("FAIL highrst t=%0d got=%h exp=%h", t, obs_all, exp_all);
      end
      if (t > 0 && t % G == 0) begin
        total++;
        if (cv_a !== 1'b1 || cnt_a[7:0] !== ((t == 400) ? 8'd1 : 8'd0)) begin
          bad++; $display("FAIL highrst_win t=%0d cv=%b cnt=%0d", t, cv_a, cnt_a[7:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    reset_cycles(2, 2'b00);
    for (int k = 0; k < 50; k++) begin
      step((k >= 5 && k < 25 && ((k - 5) % 4) < 2) ? 2'b01 : 2'b00);
      total++;
      if (obs_all !== exp_all) begin
        bad++; $display("FAIL midrst_pre t=%0d got=%h exp=%h", t, obs_all, exp_all);
      end
    end
    reset_cycles(1, 2'b00);
    for (int k = 0; k < 110; k++) begin
      step((k >= 10 && k < 22 && ((k - 10) % 4) < 2) ? 2'b01 : 2'b00);
      total++;
      if (obs_all !== exp_all) begin
        bad++; $display("FAIL midrst t=%0d got=%h exp=%h", t, obs_all, exp_all);
      end
      if (t == 49) begin
        total++;
        if (cv_a !== 1'b0) begin
          bad++; $display("FAIL midrst_oldgate t=%0d cv=%b exp 0", t, cv_a);
        end
      end
      if (t == 100) begin
        total++;
        if (cv_a !== 1'b1 || cnt_a[7:0] !== 8'd3) begin
          bad++; $display("FAIL midrst_win cv=%b cnt=%0d exp cv=1 cnt=3", cv_a, cnt_a[7:0]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] cur;
    reset_cycles(3, 2'b00);
    cur = 2'b00;
    for (int k = 0; k < 700; k++) begin
      for (int c = 0; c < 2; c++)
        if ($urandom_range(0, 99) < ((k < 400) ? 30 : 90)) cur[c] = ~cur[c];
      step(cur);
      total++;
      if (obs_all !== exp_all) begin
        bad++; $display("FAIL random t=%0d got=%h exp=%h", t, obs_all, exp_all);
      end
    end
  endtask

  initial begin
    in_rst = 1'b1;
    t = 0;
    model_clear();
    test_reset();
    test_steady();
    test_saturation();
    test_boundary();
    test_high_reset();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
